// File: rtl/addern_pkg.sv
// addern_pkg: shared helpers for the pipelined adder.
//   stages(n, chunk)   - number of pipeline stages (one CHUNK-bit slice per stage)
//   chunk_ok(n, chunk) - true when n is a non-zero multiple of chunk
package addern_pkg;

  function automatic int unsigned stages(input int unsigned n, input int unsigned chunk);
    return n / chunk;
  endfunction

  function automatic bit chunk_ok(input int unsigned n, input int unsigned chunk);
    return (chunk != 0) && (n >= chunk) && ((n % chunk) == 0);
  endfunction

endpackage

// File: rtl/pipe_addern_add_chunk.sv
// add_chunk: combinational Width-bit ripple adder slice.
//   cin      - carry into the slice LSB
//   a, b     - operand slices
//   s        - slice sum
//   cout     - carry out of the slice MSB
//   c_msb_in - carry into the slice MSB (signed overflow = cout ^ c_msb_in)
module add_chunk #(
  parameter int unsigned Width = 8
) (
  input  logic             cin,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic [Width-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  if (Width == 1) begin : g_w1
    assign c_msb_in = cin;
    assign s        = a ^ b ^ cin;
    assign cout     = (a & b) | (cin & (a ^ b));
  end else begin : g_wn
    // Add everything below the MSB first so the carry into the MSB is exposed.
    logic [Width-1:0] low;
    assign low      = {1'b0, a[Width-2:0]} + {1'b0, b[Width-2:0]} + {{(Width-1){1'b0}}, cin};
    assign c_msb_in = low[Width-1];
    assign s        = {a[Width-1] ^ b[Width-1] ^ c_msb_in, low[Width-2:0]};
    assign cout     = (a[Width-1] & b[Width-1]) | (c_msb_in & (a[Width-1] ^ b[Width-1]));
  end

endmodule

// File: rtl/pipe_addern.sv
// pipe_addern: pipelined N-bit adder, one CHUNK-bit slice per registered stage.
//   clk, rst_n            - rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   - operand handshake (in_ready = !out_valid | out_ready)
//   carryin, signed_mode  - captured with the beat, travel with it
//   X, Y                  - operands
//   out_valid / out_ready - result handshake
//   S, carryout           - {carryout, S} = X + Y + carryin
//   overflow              - unsigned: carryout; signed: C[N] ^ C[N-1]
module pipe_addern
  import addern_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         carryin,
  input  logic         signed_mode,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         carryout,
  output logic         overflow
);

  localparam int unsigned Stages = stages(N, CHUNK);

  if (!chunk_ok(N, CHUNK)) begin : g_param_check
    $fatal(1, "pipe_addern: N must be a non-zero multiple of CHUNK");
  end

  // Single global advance: the whole pipe shifts or the whole pipe holds.
  logic advance;
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < Stages; k++) begin : g_stage
    localparam int unsigned Lo = k * CHUNK;
    localparam int unsigned Bw = N - Lo;  // Y bits not yet consumed at this stage's input

    logic             in_v, in_c, in_sm;
    logic [N-1:0]     in_a;  // completed sum slices below Lo, unprocessed X from Lo up
    logic [Bw-1:0]    in_b;  // unprocessed Y from Lo up
    logic [CHUNK-1:0] sum_s;
    logic             sum_c, c_msb;
    logic             valid_d, valid_q, cy_d, cy_q;
    logic [N-1:0]     a_d, a_q;

    if (k == 0) begin : g_src
      assign in_v  = in_valid;
      assign in_c  = carryin;
      assign in_sm = signed_mode;
      assign in_a  = X;
      assign in_b  = Y;
    end else begin : g_src
      assign in_v  = g_stage[k-1].valid_q;
      assign in_c  = g_stage[k-1].cy_q;
      assign in_sm = g_stage[k-1].g_tail.sm_q;
      assign in_a  = g_stage[k-1].a_q;
      assign in_b  = g_stage[k-1].g_tail.b_q;
    end

    add_chunk #(
      .Width(CHUNK)
    ) u_add (
      .cin     (in_c),
      .a       (in_a[Lo +: CHUNK]),
      .b       (in_b[CHUNK-1:0]),
      .s       (sum_s),
      .cout    (sum_c),
      .c_msb_in(c_msb)
    );

    always_comb begin
      valid_d = valid_q;
      cy_d    = cy_q;
      a_d     = a_q;
      if (advance) begin
        valid_d          = in_v;
        cy_d             = sum_c;
        a_d              = in_a;
        a_d[Lo +: CHUNK] = sum_s;  // finished slice replaces the X slice it consumed
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
      end
    end

    if (k == Stages - 1) begin : g_tail
      // Last stage registers are the outputs, so they reset.
      logic ovf_d, ovf_q;

      always_comb begin
        ovf_d = ovf_q;
        if (advance) begin
          ovf_d = in_sm ? (sum_c ^ c_msb) : sum_c;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          cy_q  <= 1'b0;
          ovf_q <= 1'b0;
        end else begin
          a_q   <= a_d;
          cy_q  <= cy_d;
          ovf_q <= ovf_d;
        end
      end

      assign out_valid = valid_q;
      assign S         = a_q;
      assign carryout  = cy_q;
      assign overflow  = ovf_q;
    end else begin : g_tail
      localparam int unsigned Rw = Bw - CHUNK;
      logic          sm_d, sm_q;
      logic [Rw-1:0] b_d, b_q;
      logic          unused_c_msb;

      assign unused_c_msb = c_msb;  // only the top slice needs the MSB carry

      always_comb begin
        sm_d = sm_q;
        b_d  = b_q;
        if (advance) begin
          sm_d = in_sm;
          b_d  = in_b[Bw-1:CHUNK];
        end
      end

      // Intermediate data is qualified by valid_q, so it needs no reset.
      always_ff @(posedge clk) begin
        a_q  <= a_d;
        cy_q <= cy_d;
        sm_q <= sm_d;
        b_q  <= b_d;
      end
    end
  end

endmodule

// File: tb/tb_pipe_addern.sv
// tb_pipe_addern: self-checking bench for pipe_addern (N=32/CHUNK=8 and N=16/CHUNK=16).
module tb_pipe_addern;

  localparam int Lat = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, carryin, signed_mode;
  logic        out_valid, out_ready, carryout, overflow;
  logic [31:0] x, y, s;

  logic        d1_in_valid, d1_in_ready, d1_carryin, d1_signed_mode;
  logic        d1_out_valid, d1_out_ready, d1_carryout, d1_overflow;
  logic [15:0] d1_x, d1_y, d1_s;

  pipe_addern #(.N(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .carryin(carryin), .signed_mode(signed_mode), .X(x), .Y(y),
    .out_valid(out_valid), .out_ready(out_ready), .S(s), .carryout(carryout),
    .overflow(overflow)
  );

  pipe_addern #(.N(16), .CHUNK(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .carryin(d1_carryin), .signed_mode(d1_signed_mode), .X(d1_x), .Y(d1_y),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .S(d1_s), .carryout(d1_carryout),
    .overflow(d1_overflow)
  );

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } res_t;

  typedef struct {
    logic [31:0] x, y;
    logic        cin, sm;
    logic [31:0] s;
    logic        co, ov;
  } vec_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   sent = 0;
  int   recv = 0;
  res_t exp_q[$];
  res_t exp_r;
  res_t prev_out;
  logic prev_stall = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: exact integer arithmetic, signed range test on 64-bit values.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sm);
    logic [32:0] u;
    longint      ss;
    res_t        r;
    u    = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    ss   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    r.s  = u[31:0];
    r.co = u[32];
    r.ov = sm ? ((ss > 64'sd2147483647) || (ss < -64'sd2147483648)) : u[32];
    return r;
  endfunction

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (prev_stall) begin
        check("stall_hold", 64'({out_valid, s, carryout, overflow}), 64'({1'b1, prev_out}));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(x, y, carryin, signed_mode));
        sent++;
      end
      if (out_valid && out_ready) begin
        recv++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_out: got S=0x%0h with no beat outstanding", s);
        end else begin
          exp_r = exp_q.pop_front();
          check("result", 64'({s, carryout, overflow}), 64'(exp_r));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {s, carryout, overflow};
    end
  end

  task automatic send32(input vec_t v, input string tag);
    int lat;
    @(posedge clk); #1;
    x = v.x; y = v.y; carryin = v.cin; signed_mode = v.sm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(Lat));
    check({tag, "_sum"}, 64'({s, carryout, overflow}), 64'({v.s, v.co, v.ov}));
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sm, input logic [17:0] req, input string tag);
    int lat;
    @(posedge clk); #1;
    d1_x = a; d1_y = b; d1_carryin = cin; d1_signed_mode = sm; d1_in_valid = 1'b1;
    @(posedge clk); #1;
    d1_in_valid = 1'b0;
    lat = 1;
    while (!d1_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(1));
    check({tag, "_sum"}, 64'({d1_s, d1_carryout, d1_overflow}), 64'(req));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    int   base;
    logic took;

    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
    tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
    tbl[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    tbl[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0};
    tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[7] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    tbl[8] = '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0};

    rst_n = 1'b1;
    in_valid = 1'b0; carryin = 1'b0; signed_mode = 1'b0; x = '0; y = '0; out_ready = 1'b1;
    d1_in_valid = 1'b0; d1_carryin = 1'b0; d1_signed_mode = 1'b0; d1_x = '0; d1_y = '0;
    d1_out_ready = 1'b1;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'({in_ready, out_valid, s, carryout, overflow}), 64'({2'b10, 34'd0}));
    check("reset_state16", 64'({d1_in_ready, d1_out_valid, d1_s, d1_carryout, d1_overflow}),
          64'({2'b10, 18'd0}));
    rst_n = 1'b1;

    // Directed table, one isolated beat each.
    for (int i = 0; i < 9; i++) send32(tbl[i], $sformatf("tbl%0d", i));

    // Single-stage configuration.
    send16(16'h8000, 16'h8000, 1'b0, 1'b1, {16'h0000, 1'b1, 1'b1}, "s1_min_min");
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b1, {16'h8000, 1'b0, 1'b1}, "s1_max_inc");
    send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b1}, "s1_unsigned_wrap");

    // 100 back-to-back random beats; all must emerge one per cycle.
    base = recv;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      x = $urandom; y = $urandom; carryin = 1'($urandom); signed_mode = 1'($urandom);
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (Lat - 1) @(posedge clk);
    @(negedge clk); #1;
    check("burst_count", 64'(recv - base), 64'(100));
    check("burst_drain", 64'(exp_q.size()), 64'(0));

    // Continuous input with random backpressure; source holds data until taken.
    took = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (took) begin
        x = $urandom; y = $urandom; carryin = 1'($urandom); signed_mode = 1'($urandom);
      end
      in_valid  = 1'b1;
      out_ready = 1'($urandom);
      @(negedge clk);
      took = in_ready;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk); #1;
    check("stall_drain", 64'(exp_q.size()), 64'(0));
    check("stall_count", 64'(recv), 64'(sent));

    // Asynchronous reset with the first beat at the output and three behind it.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      x = 32'hFFFF_FFFF; y = 32'hFFFF_FFFF; carryin = 1'b0; signed_mode = 1'b0;
      in_valid = 1'b1;
    end
    @(posedge clk);
    #3;
    check("pre_reset_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("async_reset", 64'({in_ready, out_valid, s, carryout, overflow}), 64'({2'b10, 34'd0}));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("no_stale", 64'(out_valid), 64'(0));
    end
    send32(tbl[0], "post_reset");
    send32(tbl[3], "post_reset2");

    @(negedge clk); #1;
    check("final_drain", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_addern.md
# pipe_addern

Parametrised, pipelined N-bit adder that splits the operands into CHUNK-bit slices, with one registered slice per stage, so the carry chain is broken into short segments. It adds valid/ready flow control, selectable signed/unsigned overflow and full throughput of one add per cycle. It is the clocked successor to the combinational adder family and sits between an operand source and any arithmetic consumer that needs wide adds at high clock rates.

## Interface
- N, 32, operand/result width; must be a multiple of CHUNK
- CHUNK, 8, slice width added per stage; STAGES = N/CHUNK (1 ≤ STAGES)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low)
- in_valid  in  1  operand beat present
- in_ready  out  1  pipeline accepts a beat this cycle
- carryin  in  1  carry into bit 0
- signed_mode  in  1  1: two's-complement overflow rule; 0: unsigned rule
- X, Y  in  N  operands
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts result
- S  out  N  sum, modulo 2^N
- carryout  out  1  carry out of bit N-1
- overflow  out  1  range error per signed_mode of that beat

## Operation
- Stage k (0..STAGES-1) adds X/Y slice k plus the carry registered from stage k-1. Stage 0 uses carryin.
- Unprocessed upper slices travel forward in skew registers. Completed lower sum slices travel forward in deskew registers. Every beat leaves aligned.
- signed_mode and carryin are captured with the beat. They travel with it, never sampled later.
- Arithmetic: {carryout,S} = X + Y + carryin, exact over N+1 bits.
- overflow, computed in the last stage:
  - signed_mode=0: overflow = carryout.
  - signed_mode=1: overflow = C[N] ^ C[N-1], where C[N-1] is the carry into bit N-1.
- Flow control uses one global advance = !out_valid | out_ready.
  - in_ready = advance, combinational from out_ready/out_valid.
  - A beat is accepted when in_valid & in_ready.
  - On advance, every stage shifts one place. Stage 0 loads the new beat, or a bubble (valid=0) when there is no handshake.
  - When advance=0, every stage register and the outputs hold. S, carryout and overflow stay stable while out_valid=1 & out_ready=0.
- Bubbles pass through and occupy a slot. No compaction.
- Reset (asynchronous, any time, including mid-pipeline):
  - All stage valid bits clear to 0. out_valid=0. S=0, carryout=0, overflow=0.
  - In-flight beats are discarded.
  - in_ready=1 during and after reset, since out_valid=0.
- Data registers may be left unreset except the output registers. Only valid bits and outputs are required to reset.

## Timing
- Latency: a beat accepted at edge t presents out_valid=1 after edge t+STAGES-1, i.e. STAGES cycles from in_valid sampling to output, when there is no stall.
- Throughput: 1 beat/cycle while out_ready=1.
- Stall: each cycle out_valid & !out_ready adds exactly one cycle to every in-flight beat's latency.
- Simultaneous out handshake and in handshake in the same cycle is legal and loses no beat.
- Critical path: one CHUNK-bit ripple plus carry-in mux. No combinational path from X/Y to outputs.
- STAGES=1 degenerates to a single registered adder with latency 1.

## Structure
- Shared package addern_pkg: function stages(N,CHUNK), plus a compile-time check that N % CHUNK == 0 (elaboration error otherwise).
- Sub-module add_chunk: combinational CHUNK-bit adder with ports cin, a, b, s, cout, and c_msb_in (carry into the slice MSB, used for signed overflow in the top slice).
- pipe_addern instantiates STAGES add_chunk instances in a generate loop, plus the valid/skew/deskew registers.

## Test plan
All scenarios use N=32, CHUNK=8 unless stated.
- 0xFFFFFFFF + 0x00000001, carryin=0, signed_mode=0 -> S=0x00000000, carryout=1, overflow=1, out_valid exactly 4 cycles after accept. Same with signed_mode=1 -> overflow=0.
- 0x7FFFFFFF + 0x00000000, carryin=1, signed_mode=1 -> S=0x80000000, carryout=0, overflow=1. 0x80000000 + 0x80000000 signed -> S=0, carryout=1, overflow=1.
- 100 back-to-back random beats with out_ready=1 -> 100 results in order, one per cycle, all matching a 33-bit reference model.
- Random out_ready (50%) with continuous in_valid -> no loss or duplication. Outputs stay stable while stalled. in_ready tracks advance each cycle.
- Assert rst_n=0 mid-stream with 3 beats in flight -> out_valid=0, S=0, carryout=0, overflow=0 immediately (asynchronous). After release, the first new beat emerges with 4-cycle latency and no stale beats appear.
- N=16, CHUNK=16 (STAGES=1): 0x8000+0x8000 signed -> S=0, carryout=1, overflow=1, latency 1 cycle.
